sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised synchronous FIFO, successor of the basic circular-queue FIFO: adds configurable
//  data width, fill-level count, programmable almost-full/almost-empty flags, synchronous flush,
//  and registered overflow/underflow error pulses. FWFT or standard read port selectable.
//  Used as the general-purpose rate/elasticity buffer between producer and consumer pipelines.
// PARAMETERS
//  DATA_WIDTH     32  width of each stored word
//  FIFO_DEPTH     32  number of words; power of two, >= 2; AW = $clog2(FIFO_DEPTH)
//  FWFT           1   1: head word shown combinationally on rd_data_o; 0: registered read, 1-cycle latency
//  AFULL_THRESH   28  almost_full_o asserted when count >= AFULL_THRESH; legal range 1..FIFO_DEPTH
//  AEMPTY_THRESH  4   almost_empty_o asserted when count <= AEMPTY_THRESH; legal range 0..FIFO_DEPTH-1
// PORTS
//  clk_i           in   1           clock, all state on rising edge
//  rst_i           in   1           asynchronous active-high reset
//  flush_i         in   1           synchronous clear of FIFO contents
//  write_i         in   1           write request
//  wr_data_i       in   DATA_WIDTH  write data
//  read_i          in   1           read request
//  rd_data_o       out  DATA_WIDTH  read data
//  full_o          out  1           FIFO holds FIFO_DEPTH words
//  empty_o         out  1           FIFO holds 0 words
//  almost_full_o   out  1           count >= AFULL_THRESH
//  almost_empty_o  out  1           count <= AEMPTY_THRESH
//  count_o         out  AW+1        current number of stored words, 0..FIFO_DEPTH
//  overflow_o      out  1           1-cycle pulse: write_i seen while full
//  underflow_o     out  1           1-cycle pulse: read_i seen while empty
// BEHAVIOUR
//  - Pointers wr_ptr/rd_ptr are AW+1 bits (extra wrap bit); address = low AW bits, wraps naturally.
//  - empty_o = (wr_ptr == rd_ptr); full_o = MSBs differ, low AW bits equal. Both decode registered
//    pointers only, never current-cycle inputs. count_o = wr_ptr - rd_ptr (AW+1 bits, modulo).
//  - almost_full_o / almost_empty_o decode registered count_o combinationally.
//  - Accept rules: wr_acc = write_i & !full_o; rd_acc = read_i & !empty_o. Rejected requests change no
//    state except the error pulses. While full, a simultaneous read+write accepts only the read.
//    While empty, a simultaneous read+write accepts only the write.
//  - wr_acc: mem[wr_addr] <= wr_data_i, wr_ptr += 1. rd_acc: rd_ptr += 1. Both: both pointers advance,
//    count unchanged.
//  - FWFT=1: rd_data_o = mem[rd_addr] combinationally; valid whenever !empty_o; value is don't-care
//    while empty. A word written into an empty FIFO appears on rd_data_o the cycle after the write.
//  - FWFT=0: on rd_acc, rd_data_o <= mem[rd_addr]; valid the cycle after rd_acc. rd_data_o holds its
//    value otherwise, including across flush.
//  - overflow_o <= write_i & full_o; underflow_o <= read_i & empty_o (registered, high for one cycle
//    per offending cycle, not sticky).
//  - flush_i: next edge sets wr_ptr = rd_ptr = 0. Memory contents are not cleared. flush_i has
//    priority over write_i and read_i in the same cycle; those requests are discarded. Error pulses
//    are forced to 0 for that cycle.
//  - Reset (rst_i high, async): pointers 0, empty_o=1, full_o=0, count_o=0, almost_empty_o=1,
//    almost_full_o=0, overflow_o=0, underflow_o=0, rd_data_o=0 (FWFT=0). Memory is not reset.
//    Reset mid-operation discards all contents immediately. Outputs take reset values without a
//    clock edge.
//  - No pass-through: a word is readable at the earliest one cycle after it is written.
//  - Elaboration error if FIFO_DEPTH is not a power of two, or if either threshold is out of range.
// TESTING
//  - Reset, then write 32 words 0..31 (DEPTH=32) -> full_o=1 after 32nd edge, count_o=32,
//    almost_full_o from count 28; 33rd write -> overflow_o=1 for 1 cycle, count stays 32.
//  - Read 32 words -> data 0..31 in order (FWFT: same cycle as read_i; std: cycle after), empty_o=1,
//    almost_empty_o from count 4; extra read -> underflow_o pulse, pointers unchanged.
//  - Write 20 / read 20 repeatedly for 5 rounds (100 words) -> pointer wrap, order preserved,
//    count_o never exceeds 32.
//  - Full FIFO with write_i=read_i=1 -> read accepted, write rejected, overflow_o=1, count_o=31;
//    empty FIFO with both -> write accepted, underflow_o=1, count_o=1.
//  - count_o=10, assert flush_i together with write_i -> next cycle count_o=0, empty_o=1, no
//    overflow/underflow; next write 0xA5 then read returns 0xA5.
//  - Assert rst_i asynchronously mid-burst at count 17 -> empty_o=1 and count_o=0 before next edge;
//    repeat full suite with FWFT=0, DATA_WIDTH=8, FIFO_DEPTH=4.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with fill-level count, almost-full/almost-empty flags,
// synchronous flush and registered overflow/underflow pulses. The read port
// is either first-word-fall-through (FWFT=1) or registered with one cycle of
// latency (FWFT=0).
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 32,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          write_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          read_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Reject configurations the pointer arithmetic and flag decode cannot honour.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flags: FIFO_DEPTH must be a power of two and >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > FIFO_DEPTH)) begin : g_bad_afull
        $error("sync_fifo_flags: AFULL_THRESH must lie in 1..FIFO_DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > FIFO_DEPTH - 1)) begin : g_bad_aempty
        $error("sync_fifo_flags: AEMPTY_THRESH must lie in 0..FIFO_DEPTH-1");
    end

    localparam logic [AW:0] AFULL_LVL  = AFULL_THRESH[AW:0];
    localparam logic [AW:0] AEMPTY_LVL = AEMPTY_THRESH[AW:0];
    localparam logic [AW:0] PTR_ONE    = 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    // Status decodes only the registered pointers, so a same-cycle request
    // can never influence the flags it is qualified against.
    assign empty_o        = (wr_ptr == rd_ptr);
    assign full_o         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);
    assign count_o        = wr_ptr - rd_ptr;
    assign almost_full_o  = (count_o >= AFULL_LVL);
    assign almost_empty_o = (count_o <= AEMPTY_LVL);

    assign wr_acc = write_i && !full_o;
    assign rd_acc = read_i && !empty_o;

    // Pointer update: flush wins over any request in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write for accepted words.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; clearing it would turn RAM into flops,
        // and stale words are unreachable once the pointers are reset.
        if (wr_acc && !flush_i) mem[wr_addr] <= wr_data_i;
    end

    // Error pulses: one cycle per offending request, suppressed by flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= write_i && full_o;
            underflow_o <= read_i && empty_o;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; meaningless while empty.
        assign rd_data_o = mem[rd_addr];
    end else begin : g_std
        // Registered read: capture the head word on each accepted read and
        // hold it otherwise, including across a flush.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)                    rd_data_o <= '0;
            else if (rd_acc && !flush_i)  rd_data_o <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: two instances (32x32 FWFT, and 8-bit x 4 with a
// registered read port) share one stimulus stream; each is compared every
// cycle against a queue-based model of its FIFO.
module tb_sync_fifo_flags;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        write;
    logic        read;
    logic [31:0] wr_data;

    logic [31:0] rd_data_a;
    logic        full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
    logic [5:0]  count_a;

    logic [7:0]  rd_data_b;
    logic        full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
    logic [2:0]  count_b;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  last_b;
    logic        ovf_a_exp, unf_a_exp, ovf_b_exp, unf_b_exp;

    localparam int DA = 32, AFA = 28, AEA = 4;
    localparam int DB = 4,  AFB = 3,  AEB = 1;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH(32), .FIFO_DEPTH(DA), .FWFT(1),
        .AFULL_THRESH(AFA), .AEMPTY_THRESH(AEA)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_i(write),
        .wr_data_i(wr_data), .read_i(read), .rd_data_o(rd_data_a),
        .full_o(full_a), .empty_o(empty_a), .almost_full_o(afull_a),
        .almost_empty_o(aempty_a), .count_o(count_a),
        .overflow_o(ovf_a), .underflow_o(unf_a)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(8), .FIFO_DEPTH(DB), .FWFT(0),
        .AFULL_THRESH(AFB), .AEMPTY_THRESH(AEB)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_i(write),
        .wr_data_i(wr_data[7:0]), .read_i(read), .rd_data_o(rd_data_b),
        .full_o(full_b), .empty_o(empty_b), .almost_full_o(afull_b),
        .almost_empty_o(aempty_b), .count_o(count_b),
        .overflow_o(ovf_b), .underflow_o(unf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_b    = 8'h00;
        ovf_a_exp = 1'b0; unf_a_exp = 1'b0;
        ovf_b_exp = 1'b0; unf_b_exp = 1'b0;
    endtask

    // Applies the queue semantics for the inputs that were present at the edge.
    task automatic model_update();
        bit ra, wa, rb, wb;
        if (flush) begin
            qa.delete();
            qb.delete();
            ovf_a_exp = 1'b0; unf_a_exp = 1'b0;
            ovf_b_exp = 1'b0; unf_b_exp = 1'b0;
        end else begin
            ovf_a_exp = write && (qa.size() == DA);
            unf_a_exp = read  && (qa.size() == 0);
            ra = read  && (qa.size() != 0);
            wa = write && (qa.size() != DA);
            ovf_b_exp = write && (qb.size() == DB);
            unf_b_exp = read  && (qb.size() == 0);
            rb = read  && (qb.size() != 0);
            wb = write && (qb.size() != DB);
            if (ra) void'(qa.pop_front());
            if (wa) qa.push_back(wr_data);
            if (rb) last_b = qb.pop_front();
            if (wb) qb.push_back(wr_data[7:0]);
        end
    endtask

    task automatic check_all();
        chk("a_count",  32'(count_a),  32'(qa.size()));
        chk("a_empty",  32'(empty_a),  32'(qa.size() == 0));
        chk("a_full",   32'(full_a),   32'(qa.size() == DA));
        chk("a_afull",  32'(afull_a),  32'(qa.size() >= AFA));
        chk("a_aempty", 32'(aempty_a), 32'(qa.size() <= AEA));
        chk("a_ovf",    32'(ovf_a),    32'(ovf_a_exp));
        chk("a_unf",    32'(unf_a),    32'(unf_a_exp));
        if (qa.size() != 0) chk("a_rd_data", rd_data_a, qa[0]);
        chk("b_count",  32'(count_b),  32'(qb.size()));
        chk("b_empty",  32'(empty_b),  32'(qb.size() == 0));
        chk("b_full",   32'(full_b),   32'(qb.size() == DB));
        chk("b_afull",  32'(afull_b),  32'(qb.size() >= AFB));
        chk("b_aempty", 32'(aempty_b), 32'(qb.size() <= AEB));
        chk("b_ovf",    32'(ovf_b),    32'(ovf_b_exp));
        chk("b_unf",    32'(unf_b),    32'(unf_b_exp));
        chk("b_rd_data", 32'(rd_data_b), 32'(last_b));
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic step(input logic w, input logic r, input logic f, input logic [31:0] d);
        write   = w;
        read    = r;
        flush   = f;
        wr_data = d;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0; wr_data = '0;
        model_reset();
        #1;
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;

        // Fill with 0..31, then one write too many.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0, 32'(i));
        chk("a_full_after_32", 32'(full_a), 32'd1);
        chk("a_count_32", 32'(count_a), 32'd32);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("a_overflow_pulse", 32'(ovf_a), 32'd1);
        chk("a_count_stays_32", 32'(count_a), 32'd32);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("a_overflow_clears", 32'(ovf_a), 32'd0);

        // Drain in order, then one read too many.
        for (int i = 0; i < 32; i++) begin
            chk("a_drain_data", rd_data_a, 32'(i));
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end
        chk("a_empty_after_drain", 32'(empty_a), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("a_underflow_pulse", 32'(unf_a), 32'd1);
        chk("a_count_stays_0", 32'(count_a), 32'd0);

        // Five rounds of 20 writes / 20 reads to wrap the pointers.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, $urandom);
            for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        end

        // Simultaneous read+write while full, then while empty.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        step(1'b1, 1'b1, 1'b0, 32'h1234_5678);
        chk("a_full_rw_count", 32'(count_a), 32'd31);
        chk("a_full_rw_ovf", 32'(ovf_a), 32'd1);
        for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0000_0077);
        chk("a_empty_rw_count", 32'(count_a), 32'd1);
        chk("a_empty_rw_unf", 32'(unf_a), 32'd1);

        // Flush together with a write at count 10, then reuse.
        step(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        chk("a_count_10", 32'(count_a), 32'd10);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("a_flush_count", 32'(count_a), 32'd0);
        chk("a_flush_empty", 32'(empty_a), 32'd1);
        chk("a_flush_no_ovf", 32'(ovf_a), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0000_00A5);
        chk("a_after_flush_head", rd_data_a, 32'h0000_00A5);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("b_after_flush_read", 32'(rd_data_b), 32'h0000_00A5);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0), $urandom);

        // Asynchronous reset in the middle of a burst at count 17.
        step(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        chk("a_count_17", 32'(count_a), 32'd17);
        write = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("a_async_rst_empty", 32'(empty_a), 32'd1);
        chk("a_async_rst_count", 32'(count_a), 32'd0);
        check_all();
        write = 1'b0;
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'(i + 100));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
